// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: bus layouts, ALU selects,
// multiplier FSM encoding and a magnitude helper.
package execute_stage_pkg;

    localparam int ID_EXE_W  = 167;
    localparam int EXE_MEM_W = 154;
    localparam int ALU_CTL_W = 12;
    localparam int MUL_STEPS = 32;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int ID_MUL      = 166;
    localparam int ID_MTHI     = 165;
    localparam int ID_MTLO     = 164;
    localparam int ID_ALU_LSB  = 152;
    localparam int ID_OP1_LSB  = 120;
    localparam int ID_OP2_LSB  = 88;
    localparam int ID_MEMC_LSB = 84;
    localparam int ID_SD_LSB   = 52;
    localparam int ID_WDST_LSB = 32;

    // Bits [51:0] (mfhi..pc) sit at the same place in both buses.
    localparam int PASS_W      = 52;

    localparam int EM_MEMC_LSB = 150;
    localparam int EM_SD_LSB   = 118;
    localparam int EM_RES_LSB  = 86;
    localparam int EM_LO_LSB   = 54;
    localparam int EM_HIW      = 53;
    localparam int EM_LOW      = 52;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/execute_stage_mult_iter.sv
// Signed 32x32 shift-add multiplier, one partial product per cycle,
// working on magnitudes with a sign fix-up on the way out.
module mult_iter
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        cancel,
    input  logic        ack,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    mul_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (start && !cancel) begin
                    state_d  = MUL_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {32'h0, abs32(op_a)};
                    mplier_d = abs32(op_b);
                    neg_d    = op_a[31] ^ op_b[31];
                end
            end
            MUL_BUSY: begin
                if (cancel) begin
                    state_d = MUL_IDLE;
                    acc_d   = '0;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'(MUL_STEPS - 1)) begin
                        state_d = MUL_DONE;
                    end
                end
            end
            MUL_DONE: begin
                if (cancel) begin
                    state_d = MUL_IDLE;
                    acc_d   = '0;
                end else if (ack) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an iterative signed multiplier
// that holds the stage until the product is handed to MEM.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EXE_valid,
    input  logic [ID_EXE_W-1:0]  ID_EXE_bus_r,
    input  logic                 next_allow,
    input  logic                 cancel,
    output logic                 EXE_over,
    output logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic [4:0]           EXE_wdest,
    output logic [31:0]          EXE_pc
);

    logic                 multiply, mthi, mtlo;
    logic [ALU_CTL_W-1:0] alu_control;
    logic [31:0]          op1, op2;
    logic [3:0]           mem_control;
    logic [31:0]          store_data;
    logic [PASS_W-1:0]    pass_fields;
    logic [4:0]           shamt;

    assign multiply    = ID_EXE_bus_r[ID_MUL];
    assign mthi        = ID_EXE_bus_r[ID_MTHI];
    assign mtlo        = ID_EXE_bus_r[ID_MTLO];
    assign alu_control = ID_EXE_bus_r[ID_ALU_LSB +: ALU_CTL_W];
    assign op1         = ID_EXE_bus_r[ID_OP1_LSB +: 32];
    assign op2         = ID_EXE_bus_r[ID_OP2_LSB +: 32];
    assign mem_control = ID_EXE_bus_r[ID_MEMC_LSB +: 4];
    assign store_data  = ID_EXE_bus_r[ID_SD_LSB +: 32];
    assign pass_fields = ID_EXE_bus_r[PASS_W-1:0];
    assign shamt       = op1[4:0];

    logic [31:0] alu_result;

    always_comb begin
        alu_result = '0;
        unique case (1'b1)
            alu_control[ALU_ADD]:  alu_result = op1 + op2;
            alu_control[ALU_SUB]:  alu_result = op1 - op2;
            alu_control[ALU_SLT]:  alu_result = {31'h0, $signed(op1) < $signed(op2)};
            alu_control[ALU_SLTU]: alu_result = {31'h0, op1 < op2};
            alu_control[ALU_AND]:  alu_result = op1 & op2;
            alu_control[ALU_NOR]:  alu_result = ~(op1 | op2);
            alu_control[ALU_OR]:   alu_result = op1 | op2;
            alu_control[ALU_XOR]:  alu_result = op1 ^ op2;
            alu_control[ALU_SLL]:  alu_result = op2 << shamt;
            alu_control[ALU_SRL]:  alu_result = op2 >> shamt;
            alu_control[ALU_SRA]:  alu_result = $signed(op2) >>> shamt;
            alu_control[ALU_LUI]:  alu_result = {op2[15:0], 16'h0};
            default:               alu_result = '0;
        endcase
    end

    logic        mul_busy, mul_done;
    logic [63:0] product;

    // Losing EXE_valid mid-multiply is treated like a flush.
    mult_iter u_mult (
        .clk     (clk),
        .resetn  (resetn),
        .start   (EXE_valid & multiply),
        .cancel  (cancel | ~EXE_valid),
        .ack     (next_allow),
        .op_a    (op1),
        .op_b    (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    logic [31:0] exe_result, lo_result;
    logic        hi_write, lo_write;

    always_comb begin
        exe_result = alu_result;
        lo_result  = '0;
        if (multiply) begin
            exe_result = product[63:32];
            lo_result  = product[31:0];
        end else begin
            if (mthi) exe_result = op1;
            if (mtlo) lo_result  = op1;
        end
    end

    assign hi_write = multiply | mthi;
    assign lo_write = multiply | mtlo;

    assign EXE_over = multiply ? (EXE_valid & mul_done & ~cancel & ~mul_busy)
                               : EXE_valid;

    assign EXE_MEM_bus = {mem_control, store_data, exe_result, lo_result,
                          hi_write, lo_write, pass_fields};

    assign EXE_wdest = EXE_valid ? ID_EXE_bus_r[ID_WDST_LSB +: 5] : 5'd0;
    assign EXE_pc    = ID_EXE_bus_r[31:0];

endmodule
